// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
package pc_fetch_unit_pkg;

    localparam int unsigned DEF_WORD_SIZE = 32;
    localparam int unsigned DEF_IALIGN    = 4;

    // Fetch sequencer states: one request in flight at most.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // Number of PC low bits that must be zero for an aligned target.
    function automatic int unsigned ialign_bits(input int unsigned ialign);
        return $clog2(ialign);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next.sv
// Next-PC selection: redirect target, trap vector on misalignment, or sequential advance.
module fetch_pc_next
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned          WORD_SIZE   = DEF_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] TRAP_VECTOR = WORD_SIZE'(32'h0000_0100),
    parameter int unsigned          IALIGN      = DEF_IALIGN
) (
    input  logic [WORD_SIZE-1:0] pc,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_addr,
    input  logic                 advance,
    output logic [WORD_SIZE-1:0] next_pc_c,
    output logic                 misaligned_c
);

    localparam int unsigned          IALIGN_BITS = ialign_bits(IALIGN);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK  = WORD_SIZE'((32'd1 << IALIGN_BITS) - 32'd1);
    localparam logic [WORD_SIZE-1:0] PC_STEP     = WORD_SIZE'(IALIGN);

    // Redirect outranks the sequential advance; a misaligned target lands on the trap vector.
    always_comb begin
        misaligned_c = redirect && ((redirect_addr & ALIGN_MASK) != '0);
        next_pc_c    = pc;
        if (redirect) begin
            next_pc_c = misaligned_c ? TRAP_VECTOR : redirect_addr;
        end else if (advance) begin
            next_pc_c = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus single-outstanding instruction fetch sequencer with decode handshake,
// redirect/trap handling and a retired-instruction counter.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned          WORD_SIZE    = DEF_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = WORD_SIZE'(32'h0000_0000),
    parameter logic [WORD_SIZE-1:0] TRAP_VECTOR  = WORD_SIZE'(32'h0000_0100),
    parameter int unsigned          IALIGN       = DEF_IALIGN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_addr,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] instr_pc,
    output logic [WORD_SIZE-1:0] pc_addr,
    output logic                 trap_misaligned,
    output logic [WORD_SIZE-1:0] trap_addr,
    output logic [WORD_SIZE-1:0] retired_count
);

    localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

    fetch_state_e         state_q;
    fetch_state_e         state_d;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] next_pc;
    logic                 misaligned;
    logic                 discard_q;
    logic                 discard_d;
    logic                 capture;
    logic                 consume;
    logic                 req_d;

    fetch_pc_next #(
        .WORD_SIZE   (WORD_SIZE),
        .TRAP_VECTOR (TRAP_VECTOR),
        .IALIGN      (IALIGN)
    ) u_pc_next (
        .pc            (pc_q),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .advance       (capture),
        .next_pc_c     (next_pc),
        .misaligned_c  (misaligned)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, discard tracking and datapath strobes.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        capture   = 1'b0;
        consume   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (instr_valid && !stall) begin
                    consume = 1'b1;
                    state_d = en ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect overrides everything; an in-flight response must still be drained.
        if (redirect) begin
            capture = 1'b0;
            consume = 1'b0;
            case (state_q)
                ST_REQ: begin
                    discard_d = 1'b1;
                    state_d   = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        discard_d = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        req_d = (state_d == ST_REQ);
    end

    // PC, request strobe and discard flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_VECTOR;
            imem_req  <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            pc_q      <= next_pc;
            imem_req  <= req_d;
            discard_q <= discard_d;
        end
    end

    // Captured instruction presented to decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            if (redirect || consume) begin
                instr_valid <= 1'b0;
            end else if (capture) begin
                instr_valid <= 1'b1;
            end
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc_q;
            end
        end
    end

    // Misalignment trap reporting and retirement counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_misaligned <= 1'b0;
            trap_addr       <= '0;
            retired_count   <= '0;
        end else begin
            trap_misaligned <= misaligned;
            if (misaligned) begin
                trap_addr <= redirect_addr;
            end
            if (consume) begin
                retired_count <= retired_count + ONE;
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc_addr   = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized checks of pc_fetch_unit against a transaction-level model.
module tb_pc_fetch_unit;

    localparam int unsigned    W   = 32;
    localparam logic [W-1:0]   RV  = 32'h0000_0000;
    localparam logic [W-1:0]   TV  = 32'h0000_0100;
    localparam logic [W-1:0]   RV2 = 32'hFFFF_FFFC;
    localparam logic [W-1:0]   XM  = 32'hA5A5_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         stall = 1'b0;
    logic         redirect = 1'b0;
    logic [W-1:0] redirect_addr = '0;
    logic         imem_rvalid = 1'b0;
    logic [W-1:0] imem_rdata = '0;
    logic         imem_req, instr_valid, trap_misaligned;
    logic [W-1:0] imem_addr, instr, instr_pc, pc_addr, trap_addr, retired_count;

    logic         imem_rvalid2 = 1'b0;
    logic [W-1:0] imem_rdata2 = '0;
    logic         imem_req2, instr_valid2, trap_misaligned2;
    logic [W-1:0] imem_addr2, instr2, instr_pc2, pc_addr2, trap_addr2, retired_count2;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .pc_addr(pc_addr),
        .trap_misaligned(trap_misaligned), .trap_addr(trap_addr), .retired_count(retired_count)
    );

    pc_fetch_unit #(.RESET_VECTOR(RV2)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .stall(1'b0), .redirect(1'b0),
        .redirect_addr('0), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .instr_valid(instr_valid2),
        .instr(instr2), .instr_pc(instr_pc2), .pc_addr(pc_addr2),
        .trap_misaligned(trap_misaligned2), .trap_addr(trap_addr2), .retired_count(retired_count2)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: next instruction address decode should see, retire count, trap expectations.
    logic [W-1:0] m_pc = RV;
    logic [W-1:0] m_trap_addr = '0;
    logic         m_trap = 1'b0;
    logic [W-1:0] m_ret = '0;
    logic [W-1:0] m_pc2 = RV2;
    logic [W-1:0] d2_log[$];

    // Memory responders: one outstanding request each.
    int           lat = 1;
    int           cnt = 0;
    logic [W-1:0] paddr = '0;
    int           cnt2 = 0;
    logic [W-1:0] paddr2 = '0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RV; m_ret = '0; m_trap = 1'b0; m_trap_addr = '0;
        m_pc2 = RV2; cnt2 = 0; imem_rvalid2 = 1'b0;
        d2_log.delete();
    endtask

    // Advance one clock: update model for the coming edge, then respond and check at negedge.
    task automatic cyc();
        logic cons;
        cons = rst && instr_valid && !stall && !redirect;
        if (rst && redirect) begin
            if (redirect_addr[1:0] != 2'b00) begin
                m_pc = TV; m_trap_addr = redirect_addr; m_trap = 1'b1;
            end else begin
                m_pc = redirect_addr; m_trap = 1'b0;
            end
        end else begin
            m_trap = 1'b0;
            if (cons) begin
                m_pc = m_pc + 32'd4;
                m_ret = m_ret + 32'd1;
            end
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = paddr ^ XM; end
        end
        if (imem_req) begin paddr = imem_addr; cnt = lat; end
        imem_rvalid2 = 1'b0;
        if (cnt2 > 0) begin
            cnt2--;
            if (cnt2 == 0) begin imem_rvalid2 = 1'b1; imem_rdata2 = paddr2 ^ XM; end
        end
        if (imem_req2) begin paddr2 = imem_addr2; cnt2 = 1; end

        chk("retired", retired_count, m_ret);
        chk("trap_pulse", W'(trap_misaligned), W'(m_trap));
        chk("trap_addr", trap_addr, m_trap_addr);
        if (imem_req) chk("imem_addr", imem_addr, m_pc);
        if (instr_valid) begin
            chk("instr_pc", instr_pc, m_pc);
            chk("instr", instr, m_pc ^ XM);
        end
        if (imem_req2) begin
            chk("wrap_imem_addr", imem_addr2, m_pc2);
            d2_log.push_back(imem_addr2);
            m_pc2 = m_pc2 + 32'd4;
        end
    endtask

    task automatic sync_reset();
        rst = 1'b0;
        cnt = 0; imem_rvalid = 1'b0;
        model_reset();
        cyc(); cyc();
        rst = 1'b1;
    endtask

    initial begin
        logic [W-1:0] held_instr, held_pc;
        logic         seen;

        // Reset state
        cyc();
        chk("rst_pc", pc_addr, RV);
        chk("rst_req", W'(imem_req), '0);
        chk("rst_valid", W'(instr_valid), '0);
        chk("rst_instr", instr, '0);
        chk("rst_wrap_pc", pc_addr2, RV2);

        // 1: free-running fetch, 1-cycle memory
        lat = 1; en = 1'b1; rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk("t1_valid_cadence", W'(instr_valid), W'(i % 3 == 0));
        end
        cyc();
        chk("t1_retired3", retired_count, 32'd3);
        // 5: wrap-around instance fetched FFFF_FFFC then 0
        chk("t5_wrap_n", W'(d2_log.size() >= 2), W'(1));
        if (d2_log.size() >= 2) begin
            chk("t5_first", d2_log[0], 32'hFFFF_FFFC);
            chk("t5_second", d2_log[1], 32'h0000_0000);
        end

        // 2: stall after capture of pc 0x4
        sync_reset();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            seen = instr_valid && (instr_pc == 32'h4);
        end
        chk("t2_capture_seen", W'(seen), W'(1));
        stall = 1'b1;
        held_instr = instr; held_pc = instr_pc;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_instr_held", instr, held_instr);
            chk("t2_pc_held", instr_pc, held_pc);
            chk("t2_valid_held", W'(instr_valid), W'(1));
            chk("t2_no_req", W'(imem_req), '0);
            chk("t2_ret_held", retired_count, 32'd1);
        end
        stall = 1'b0;
        lat = 3;
        cyc();
        chk("t2_retire", retired_count, 32'd2);
        chk("t2_req", W'(imem_req), W'(1));
        chk("t2_req_addr", imem_addr, 32'h8);

        // 3: redirect during WAIT with a 3-cycle memory
        cyc();
        redirect = 1'b1; redirect_addr = 32'h40;
        cyc();
        redirect = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            chk("t3_no_valid", W'(instr_valid), '0);
            seen = imem_req;
        end
        chk("t3_req_seen", W'(seen), W'(1));
        chk("t3_req_addr", imem_addr, 32'h40);

        // 4: misaligned redirect while holding an instruction
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            seen = instr_valid;
        end
        chk("t4_valid_seen", W'(seen), W'(1));
        redirect = 1'b1; redirect_addr = 32'h42;
        cyc();
        redirect = 1'b0;
        chk("t4_trap", W'(trap_misaligned), W'(1));
        chk("t4_trap_addr", trap_addr, 32'h42);
        chk("t4_pc", pc_addr, TV);
        chk("t4_dropped", W'(instr_valid), '0);
        cyc();
        chk("t4_trap_pulse_end", W'(trap_misaligned), '0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (!imem_req) cyc();
            seen = imem_req;
        end
        chk("t4_req_addr", imem_addr, TV);

        // 6: asynchronous reset mid-WAIT; late response must be ignored
        lat = 5;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            seen = imem_req;
        end
        chk("t6_req_seen", W'(seen), W'(1));
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("t6_pc", pc_addr, RV);
        chk("t6_req", W'(imem_req), '0);
        chk("t6_valid", W'(instr_valid), '0);
        chk("t6_instr", instr, '0);
        chk("t6_instr_pc", instr_pc, '0);
        chk("t6_trap", W'(trap_misaligned), '0);
        chk("t6_trap_addr", trap_addr, '0);
        chk("t6_retired", retired_count, '0);
        model_reset();
        en = 1'b0;
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t6_idle_valid", W'(instr_valid), '0);
            chk("t6_idle_req", W'(imem_req), '0);
            chk("t6_idle_pc", pc_addr, RV);
        end

        // Randomized traffic
        en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            en    = ($urandom_range(0, 9) < 8);
            stall = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 19) == 0);
            redirect_addr = W'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) != 0) redirect_addr[1:0] = 2'b00;
            if (cnt == 0 && !imem_req) lat = $urandom_range(1, 4);
            cyc();
        end
        redirect = 1'b0; stall = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
